// File: rtl/prog_loader.sv
// Streams bytes into program RAM as little-endian words, then validates a trailing
// 8-bit additive checksum before releasing the downstream core from reset.
module prog_loader #(
  parameter int unsigned RAM_WIDTH       = 32,
  parameter int unsigned RAM_ADDR_BITS   = 9,
  parameter int unsigned PROG_START_ADDR = 0,
  parameter int unsigned PROG_END_ADDR   = 14
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [7:0]               s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic                     mem_we_o,
  output logic [RAM_ADDR_BITS-1:0] mem_addr_o,
  output logic [RAM_WIDTH-1:0]     mem_wdata_o,
  output logic                     core_reset_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int unsigned NumBytes = RAM_WIDTH / 8;
  localparam int unsigned CntW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;

  localparam logic [CntW-1:0]          LastByte  = CntW'(NumBytes - 1);
  localparam logic [RAM_ADDR_BITS-1:0] StartAddr = RAM_ADDR_BITS'(PROG_START_ADDR);
  localparam logic [RAM_ADDR_BITS-1:0] EndAddr   = RAM_ADDR_BITS'(PROG_END_ADDR);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StCheck,
    StDone,
    StErr
  } state_e;

  state_e                   state_q;
  logic [RAM_ADDR_BITS-1:0] word_addr_q;
  logic [CntW-1:0]          byte_cnt_q;
  logic [7:0]               csum_q;
  logic [RAM_WIDTH-1:0]     word_q;

  logic                     s_ready_q;
  logic                     mem_we_q;
  logic [RAM_ADDR_BITS-1:0] mem_addr_q;
  logic [RAM_WIDTH-1:0]     mem_wdata_q;
  logic                     core_reset_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_q;

  logic                     accept;
  logic [RAM_WIDTH-1:0]     word_asm;
  logic [7:0]               csum_sum;

  always_comb begin
    accept   = s_valid_i & s_ready_q;
    word_asm = word_q;
    word_asm[{byte_cnt_q, 3'b000} +: 8] = s_data_i;
    csum_sum = csum_q + s_data_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      word_addr_q  <= '0;
      byte_cnt_q   <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      s_ready_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start_i) begin
            state_q      <= StRecv;
            word_addr_q  <= StartAddr;
            byte_cnt_q   <= '0;
            csum_q       <= '0;
            word_q       <= '0;
            s_ready_q    <= 1'b1;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
          end
        end

        StRecv: begin
          if (accept) begin
            word_q <= word_asm;
            csum_q <= csum_sum;
            if (byte_cnt_q == LastByte) begin
              // Issue the write straight from the assembled word for 1-cycle latency.
              state_q     <= StWrite;
              s_ready_q   <= 1'b0;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= word_addr_q;
              mem_wdata_q <= word_asm;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end

        StWrite: begin
          mem_we_q  <= 1'b0;
          s_ready_q <= 1'b1;
          if (word_addr_q == EndAddr) begin
            state_q <= StCheck;
          end else begin
            state_q     <= StRecv;
            word_addr_q <= word_addr_q + 1'b1;
            byte_cnt_q  <= '0;
          end
        end

        StCheck: begin
          if (accept) begin
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            if (s_data_i == csum_q) begin
              state_q      <= StDone;
              done_q       <= 1'b1;
              core_reset_q <= 1'b0;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end

        default: begin
          state_q      <= StIdle;
          s_ready_q    <= 1'b0;
          mem_we_q     <= 1'b0;
          core_reset_q <= 1'b1;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready_o    = s_ready_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign core_reset_o = core_reset_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter RAM_WIDTH, default 32, instruction word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter RAM_ADDR_BITS, default 9, program RAM address width.
REQ-003 Parameter PROG_START_ADDR, default 0, first word address written.
REQ-004 Parameter PROG_END_ADDR, default 14, last word address written (inclusive), SHALL be >= PROG_START_ADDR.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle load request.
REQ-008 s_data  input  8  byte stream payload.
REQ-009 s_valid  input  1  s_data valid.
REQ-010 s_ready  output  1  loader accepts byte this cycle.
REQ-011 mem_we  output  1  program RAM write strobe.
REQ-012 mem_addr  output  RAM_ADDR_BITS  program RAM word address.
REQ-013 mem_wdata  output  RAM_WIDTH  program RAM write data.
REQ-014 core_reset  output  1  held-reset to downstream processor.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  load completed, checksum good.
REQ-017 err  output  1  load failed on checksum.

Function
REQ-018 FSM states SHALL be IDLE, RECV, WRITE, CHECK, DONE, ERR.
REQ-019 A byte SHALL be accepted only in a cycle with s_valid=1 and s_ready=1; s_ready=1 only in RECV and CHECK.
REQ-020 IDLE/DONE/ERR + start=1 -> RECV; word address := PROG_START_ADDR, byte count := 0, checksum := 0, done := 0, err := 0.
REQ-021 start SHALL be ignored in RECV, WRITE and CHECK.
REQ-022 RECV: bytes assembled little-endian (first byte -> bits [7:0]); each accepted byte added to an 8-bit checksum, modulo 256.
REQ-023 Acceptance of byte RAM_WIDTH/8 of a word -> WRITE next cycle.
REQ-024 WRITE lasts exactly one cycle: mem_we=1, mem_addr=current word address, mem_wdata=assembled word; latency from accepting the word's last byte to mem_we SHALL be 1 cycle.
REQ-025 WRITE exit: address == PROG_END_ADDR -> CHECK; else address+1, byte count 0 -> RECV.
REQ-026 CHECK: one accepted byte compared with the checksum; equal -> DONE, else -> ERR; the checksum byte SHALL NOT be added to the sum.
REQ-027 mem_we SHALL be 0 in all states except WRITE; mem_addr/mem_wdata hold last values otherwise.
REQ-028 busy=1 in RECV, WRITE, CHECK; done=1 only in DONE; err=1 only in ERR.
REQ-029 core_reset SHALL be 1 in every state except DONE; it SHALL go 0 the cycle DONE is entered and return to 1 when a new start is accepted.
REQ-030 s_valid gaps of any length SHALL stall the load without data loss or timeout.

Reset
REQ-031 reset=1 SHALL immediately force IDLE, s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, busy=0, done=0, err=0, checksum=0, byte count=0.
REQ-032 reset asserted mid-load SHALL discard the partial word; RAM contents already written are not restored.

Verification
REQ-033 Default params, start, 60 payload bytes with word 0 = 13 05 10 00 -> mem_we at addr 0 with mem_wdata=0x00100513, 15 writes at addrs 0..14, correct checksum -> done=1, core_reset=0.
REQ-034 Same load with s_valid deasserted 3 cycles between every byte -> identical RAM writes and outcome.
REQ-035 Load with checksum byte = correct+1 -> err=1, done=0, core_reset stays 1; subsequent start plus good stream -> done=1.
REQ-036 reset asserted after 6 bytes (1 word written) -> outputs at reset values same cycle; new start reloads from addr 0.
REQ-037 start pulsed during RECV -> ignored, address/byte count unchanged, load completes normally.
REQ-038 PROG_START_ADDR=PROG_END_ADDR=5 -> exactly one mem_we at addr 5, then CHECK.
